// File: rtl/uart_cmd_frame_tx_if.sv
// Command handshake bundle between a host driver and uart_cmd_frame_tx.
// The inj_perr field exists only when UART_CMD_TX_PERR_INJ_EN is defined.
interface uart_cmd_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_type;
    logic [DATA_WIDTH-1:0] arg0;
    logic [DATA_WIDTH-1:0] arg1;
    logic [DATA_WIDTH-1:0] arg2;
    logic                  par_en;
    logic                  par_typ;
`ifdef UART_CMD_TX_PERR_INJ_EN
    logic                  inj_perr;
`endif

    modport master (
        output cmd_valid, cmd_type, arg0, arg1, arg2, par_en, par_typ,
`ifdef UART_CMD_TX_PERR_INJ_EN
        output inj_perr,
`endif
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, arg0, arg1, arg2, par_en, par_typ,
`ifdef UART_CMD_TX_PERR_INJ_EN
        input  inj_perr,
`endif
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_frame_tx.sv
// Serializes one accepted command into its sequence of UART frames on tx_out.
// Optional feature: UART_CMD_TX_PERR_INJ_EN adds inj_perr to invert every parity bit of a command.
module uart_cmd_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8,
    parameter int GAP_BITS   = 1
) (
    input  logic               uart_clk,
    input  logic               rst,
    uart_cmd_frame_tx_if.slave cmd,
    output logic               tx_out,
    output logic               busy,
    output logic               frame_done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;

    state_t                state_r;
    logic [PW-1:0]         presc_r;
    logic [BW-1:0]         bit_idx_r;
    logic [GW-1:0]         gap_cnt_r;
    logic [1:0]            frame_idx_r;
    logic [1:0]            cmd_type_r;
    logic [DATA_WIDTH-1:0] arg0_r;
    logic [DATA_WIDTH-1:0] arg1_r;
    logic [DATA_WIDTH-1:0] arg2_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  tx_out_r;
    logic                  busy_r;
    logic                  frame_done_r;
`ifdef UART_CMD_TX_PERR_INJ_EN
    logic                  inj_r;
`endif

    logic                  accept_s;
    logic                  bit_end_s;
    logic                  frame_end_s;
    logic                  last_frame_s;
    logic                  par_bit_s;
    logic [DATA_WIDTH-1:0] cur_byte_s;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] b, input logic odd);
        return odd ? ~^b : ^b;
    endfunction

    function automatic logic [1:0] last_frame_idx(input logic [1:0] t);
        case (t)
            2'd0:    return 2'd2;
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            2'd3:    return 2'd1;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] header_byte(input logic [1:0] t);
        case (t)
            2'd0:    return DATA_WIDTH'(8'hAA);
            2'd1:    return DATA_WIDTH'(8'hBB);
            2'd2:    return DATA_WIDTH'(8'hCC);
            2'd3:    return DATA_WIDTH'(8'hDD);
            default: return DATA_WIDTH'(8'hAA);
        endcase
    endfunction

    assign cmd.cmd_ready = ~busy_r & ~rst;
    assign accept_s      = cmd.cmd_valid & cmd.cmd_ready;
    assign bit_end_s     = (state_r != IDLE) && (presc_r == PW'(PRESCALE - 1));
    assign frame_end_s   = bit_end_s &&
                           (((state_r == STOP) && (GAP_BITS == 0)) ||
                            ((state_r == GAP) && (gap_cnt_r == GW'(GAP_BITS - 1))));
    assign last_frame_s  = (frame_idx_r == last_frame_idx(cmd_type_r));

`ifdef UART_CMD_TX_PERR_INJ_EN
    assign par_bit_s = parity_bit(cur_byte_s, par_typ_r) ^ inj_r;
`else
    assign par_bit_s = parity_bit(cur_byte_s, par_typ_r);
`endif

    // Byte carried by the current frame: header first, then the operands in order.
    always_comb begin
        cur_byte_s = arg0_r;
        case (frame_idx_r)
            2'd0:    cur_byte_s = header_byte(cmd_type_r);
            2'd1:    cur_byte_s = arg0_r;
            2'd2:    cur_byte_s = arg1_r;
            2'd3:    cur_byte_s = arg2_r;
            default: cur_byte_s = arg0_r;
        endcase
    end

    // Frame sequencer; tx_out_r always holds the bit named by state_r.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            presc_r      <= PW'(0);
            bit_idx_r    <= BW'(0);
            gap_cnt_r    <= GW'(0);
            frame_idx_r  <= 2'd0;
            cmd_type_r   <= 2'd0;
            arg0_r       <= DATA_WIDTH'(0);
            arg1_r       <= DATA_WIDTH'(0);
            arg2_r       <= DATA_WIDTH'(0);
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            shift_r      <= DATA_WIDTH'(0);
            tx_out_r     <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef UART_CMD_TX_PERR_INJ_EN
            inj_r        <= 1'b0;
`endif
        end else begin
            frame_done_r <= (state_r == STOP) && bit_end_s;
            if (state_r == IDLE) begin
                tx_out_r <= 1'b1;
                if (accept_s) begin
                    cmd_type_r  <= cmd.cmd_type;
                    arg0_r      <= cmd.arg0;
                    arg1_r      <= cmd.arg1;
                    arg2_r      <= cmd.arg2;
                    par_en_r    <= cmd.par_en;
                    par_typ_r   <= cmd.par_typ;
`ifdef UART_CMD_TX_PERR_INJ_EN
                    inj_r       <= cmd.inj_perr;
`endif
                    state_r     <= START;
                    tx_out_r    <= 1'b0;
                    busy_r      <= 1'b1;
                    presc_r     <= PW'(0);
                    bit_idx_r   <= BW'(0);
                    gap_cnt_r   <= GW'(0);
                    frame_idx_r <= 2'd0;
                end
            end else if (!bit_end_s) begin
                presc_r <= presc_r + PW'(1);
            end else begin
                presc_r <= PW'(0);
                if (frame_end_s) begin
                    if (last_frame_s) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        tx_out_r <= 1'b1;
                    end else begin
                        state_r     <= START;
                        frame_idx_r <= frame_idx_r + 2'd1;
                        tx_out_r    <= 1'b0;
                    end
                end else begin
                    case (state_r)
                        START: begin
                            state_r   <= DATA;
                            bit_idx_r <= BW'(0);
                            tx_out_r  <= cur_byte_s[0];
                            shift_r   <= {1'b0, cur_byte_s[DATA_WIDTH-1:1]};
                        end
                        DATA: begin
                            if (bit_idx_r == BW'(DATA_WIDTH - 1)) begin
                                state_r  <= par_en_r ? PARITY : STOP;
                                tx_out_r <= par_en_r ? par_bit_s : 1'b1;
                            end else begin
                                bit_idx_r <= bit_idx_r + BW'(1);
                                tx_out_r  <= shift_r[0];
                                shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                            end
                        end
                        PARITY: begin
                            state_r  <= STOP;
                            tx_out_r <= 1'b1;
                        end
                        STOP: begin
                            state_r   <= GAP;
                            gap_cnt_r <= GW'(0);
                            tx_out_r  <= 1'b1;
                        end
                        GAP: begin
                            gap_cnt_r <= gap_cnt_r + GW'(1);
                            tx_out_r  <= 1'b1;
                        end
                        default: begin
                            state_r  <= IDLE;
                            busy_r   <= 1'b0;
                            tx_out_r <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign tx_out     = tx_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Randomized bench for uart_cmd_frame_tx: a per-cycle line/flag model built from frame rules.
module tb_uart_cmd_frame_tx;
    localparam int P = 8;
    localparam int G = 1;

    typedef struct packed {
        logic tx;
        logic busy;
        logic fd;
    } exp_t;

    logic clk;
    logic rst;
    logic tx_out;
    logic busy;
    logic frame_done;

    int   passed;
    int   total;
    exp_t exp_q[$];
    logic model_busy;

    uart_cmd_frame_tx_if #(.DATA_WIDTH(8)) cif ();

    uart_cmd_frame_tx #(
        .DATA_WIDTH (8),
        .PRESCALE   (P),
        .GAP_BITS   (G)
    ) dut (
        .uart_clk   (clk),
        .rst        (rst),
        .cmd        (cif),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic check_l(input string name, input logic act, input logic req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic model_par(input logic [7:0] b, input logic odd, input logic inj);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return logic'(ones % 2) ^ odd ^ inj;
    endfunction

    // Expand a command into its cycle-by-cycle expected line, busy and frame_done values.
    task automatic push_cmd(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic pe, input logic pt, input logic inj);
        logic [7:0] bytes [4];
        int         nf;
        int         fd_idx[$];
        logic       bits[$];
        case (t)
            2'd0:    begin bytes[0] = 8'hAA; nf = 3; end
            2'd1:    begin bytes[0] = 8'hBB; nf = 2; end
            2'd2:    begin bytes[0] = 8'hCC; nf = 4; end
            default: begin bytes[0] = 8'hDD; nf = 2; end
        endcase
        bytes[1] = a0;
        bytes[2] = a1;
        bytes[3] = a2;
        for (int f = 0; f < nf; f++) begin
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(bytes[f][i]);
            if (pe) bits.push_back(model_par(bytes[f], pt, inj));
            bits.push_back(1'b1);
            foreach (bits[k])
                for (int c = 0; c < P; c++) exp_q.push_back('{tx: bits[k], busy: 1'b1, fd: 1'b0});
            fd_idx.push_back(exp_q.size());
            for (int c = 0; c < G * P; c++) exp_q.push_back('{tx: 1'b1, busy: 1'b1, fd: 1'b0});
        end
        foreach (fd_idx[k]) begin
            if (fd_idx[k] < exp_q.size()) exp_q[fd_idx[k]].fd = 1'b1;
            else exp_q.push_back('{tx: 1'b1, busy: 1'b0, fd: 1'b1});
        end
    endtask

    // Reference acceptance: valid seen at an edge ending a non-busy, out-of-reset cycle.
    always @(posedge clk) begin
        if (!rst && cif.cmd_valid && !model_busy) begin : accept_blk
            logic inj_v;
            inj_v = 1'b0;
`ifdef UART_CMD_TX_PERR_INJ_EN
            inj_v = cif.inj_perr;
`endif
            push_cmd(cif.cmd_type, cif.arg0, cif.arg1, cif.arg2, cif.par_en, cif.par_typ, inj_v);
        end
    end

    // Per-cycle comparison of every output against the model, sampled mid-cycle.
    always @(negedge clk) begin : cmp_blk
        exp_t e;
        logic er;
        if (rst) begin
            exp_q.delete();
            model_busy = 1'b0;
            e  = '{tx: 1'b1, busy: 1'b0, fd: 1'b0};
            er = 1'b0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_busy = e.busy;
            er = ~e.busy;
        end else begin
            model_busy = 1'b0;
            e  = '{tx: 1'b1, busy: 1'b0, fd: 1'b0};
            er = 1'b1;
        end
        check_l("tx_out", tx_out, e.tx);
        check_l("busy", busy, e.busy);
        check_l("frame_done", frame_done, e.fd);
        check_l("cmd_ready", cif.cmd_ready, er);
    end

    task automatic send_cmd(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic pe, input logic pt, input logic inj,
                            input bit wait_done, output int lat, output int fds);
        int w;
        w = 0;
        lat = 0;
        fds = 0;
        @(negedge clk);
        while (!cif.cmd_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) check("ready_wait_timeout", w, 0);
        cif.cmd_type = t;
        cif.arg0 = a0;
        cif.arg1 = a1;
        cif.arg2 = a2;
        cif.par_en = pe;
        cif.par_typ = pt;
`ifdef UART_CMD_TX_PERR_INJ_EN
        cif.inj_perr = inj;
`else
        if (inj) cif.par_typ = pt;
`endif
        cif.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        lat = 1;
        fds = int'(frame_done);
        if (wait_done) begin
            while (!cif.cmd_ready && lat < 5000) begin
                @(negedge clk);
                lat++;
                fds += int'(frame_done);
            end
            if (lat >= 5000) check("cmd_done_timeout", lat, 0);
        end
    endtask

    initial begin
        int lat;
        int fds;
        passed = 0;
        total = 0;
        model_busy = 1'b0;
        rst = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_type = 2'd0;
        cif.arg0 = 8'h00;
        cif.arg1 = 8'h00;
        cif.arg2 = 8'h00;
        cif.par_en = 1'b0;
        cif.par_typ = 1'b0;
`ifdef UART_CMD_TX_PERR_INJ_EN
        cif.inj_perr = 1'b0;
`endif

        // Pin the model against hand-computed frame contents.
        push_cmd(2'd0, 8'h0A, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
        check("model_rfwr_len", exp_q.size(), 288);
        for (int f = 0; f < 3; f++) check_l("model_rfwr_par", exp_q[(f * 12 + 9) * P].tx, 1'b0);
        check_l("model_rfwr_arg0_b1", exp_q[(12 + 2) * P].tx, 1'b1);
        check_l("model_rfwr_fd0", exp_q[88].fd, 1'b1);
        exp_q.delete();
        push_cmd(2'd2, 8'h08, 8'h04, 8'h02, 1'b1, 1'b0, 1'b0);
        check_l("model_alu_par0", exp_q[9 * P].tx, 1'b0);
        for (int f = 1; f < 4; f++) check_l("model_alu_par", exp_q[(f * 12 + 9) * P].tx, 1'b1);
        exp_q.delete();
        push_cmd(2'd1, 8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("model_rfrd_len", exp_q.size(), 176);
        exp_q.delete();
        push_cmd(2'd3, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check_l("model_nop_par0", exp_q[9 * P].tx, 1'b1);
        check_l("model_nop_par1", exp_q[(12 + 9) * P].tx, 1'b1);
        exp_q.delete();

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        send_cmd(2'd0, 8'h0A, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, lat, fds);
        check("rfwr_ready_latency", lat - 1, 288);
        check("rfwr_frame_done_cnt", fds, 3);
        send_cmd(2'd2, 8'h08, 8'h04, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, lat, fds);
        check("alu_frame_done_cnt", fds, 4);
        check("alu_ready_latency", lat - 1, 384);
        send_cmd(2'd1, 8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, lat, fds);
        check("rfrd_ready_latency", lat - 1, 176);
        send_cmd(2'd3, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, lat, fds);
        check("nop_frame_done_cnt", fds, 2);
`ifdef UART_CMD_TX_PERR_INJ_EN
        send_cmd(2'd0, 8'h0A, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, lat, fds);
        cif.inj_perr = 1'b0;
`endif

        // Reset in the middle of the second frame's data bits.
        send_cmd(2'd0, 8'h0A, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, lat, fds);
        repeat (108) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_l("rst_tx_high", tx_out, 1'b1);
        check_l("rst_busy_low", busy, 1'b0);
        check_l("rst_ready_low", cif.cmd_ready, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        send_cmd(2'd1, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, lat, fds);
        check("post_rst_rfrd_latency", lat - 1, 192);

        // Random traffic: fields churn every cycle, valid mostly high for back-to-back starts.
        repeat (8000) begin
            @(negedge clk);
            cif.cmd_valid = ($urandom_range(0, 3) != 0);
            cif.cmd_type = 2'($urandom_range(0, 3));
            cif.arg0 = 8'($urandom);
            cif.arg1 = 8'($urandom);
            cif.arg2 = 8'($urandom);
            cif.par_en = 1'($urandom);
            cif.par_typ = 1'($urandom);
`ifdef UART_CMD_TX_PERR_INJ_EN
            cif.inj_perr = 1'($urandom);
`endif
        end
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        begin : drain_blk
            int w;
            w = 0;
            while (!cif.cmd_ready && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) check("drain_timeout", w, 0);
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_cmd_frame_tx.md
# uart_cmd_frame_tx

Host-side command initiator for the UART control system: it accepts one command per valid/ready handshake and serializes it into the exact UART frame sequence that SYS_TOP's receiver decodes on RX_IN. Each frame carries a start bit, 8 data bits LSB first, an optional even/odd parity bit and a stop bit. The block serves as a synthesizable stimulus source for system benches and as the master side in loop-back builds.

## Interface
- DATA_WIDTH, 8, width of every frame's data field
- PRESCALE, 8, UART_CLK cycles per bit; legal range is 2 or more
- GAP_BITS, 1, idle bit-times (TX_OUT=1) inserted after every stop bit; legal range is 0 or more
- UART_CLK  in  1  sole clock; all logic is on the rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block can accept a command; reset value 0 while RST is high, 1 afterwards
- CMD_TYPE  in  2  0=RF_WR, 1=RF_RD, 2=ALU_W_OP, 3=ALU_W_NOP
- ARG0, ARG1, ARG2  in  DATA_WIDTH each  command operands
- PAR_EN  in  1  parity bit present
- PAR_TYP  in  1  0=even, 1=odd
- TX_OUT  out  1  serial line; reset value 1
- BUSY  out  1  a command is in progress; reset value 0
- FRAME_DONE  out  1  one-cycle pulse at the end of each stop bit; reset value 0

## Operation
- A command is accepted on a rising edge where CMD_VALID=1 and CMD_READY=1. CMD_TYPE, ARG0-2, PAR_EN and PAR_TYP are latched at that edge and are ignored until the next acceptance.
- Frame sequences by command type:
  - RF_WR: 0xAA, ARG0 (address), ARG1 (data).
  - RF_RD: 0xBB, ARG0.
  - ALU_W_OP: 0xCC, ARG0 (operand A), ARG1 (operand B), ARG2 (function).
  - ALU_W_NOP: 0xDD, ARG0 (function).
- States are IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE goes to START on acceptance.
  - START goes to DATA.
  - DATA runs 8 bits, then goes to PARITY if PAR_EN=1, otherwise to STOP.
  - PARITY goes to STOP.
  - STOP goes to GAP, or skips GAP when GAP_BITS=0.
  - After GAP (or STOP when GAP_BITS=0), the block goes to START if frames remain, otherwise to IDLE.
- Counters:
  - Prescale counter 0..PRESCALE-1.
  - Bit index 0..7.
  - Gap counter 0..GAP_BITS-1.
  - Frame index 0..3, compared against a per-type frame count of 3, 2, 4 or 2.
- Parity: even gives ^data, odd gives ~^data, computed over the latched frame byte.
- BUSY=1 from the cycle after acceptance through the last gap cycle. CMD_READY equals ~BUSY & ~RST.
- CMD_VALID while BUSY=1 is ignored. No queuing.

## Timing
- TX_OUT is registered. The start bit appears the cycle after the accepting edge.
- Every bit, including each gap bit, is held for exactly PRESCALE cycles.
- Frame length is (10+PAR_EN+GAP_BITS)*PRESCALE cycles. Command duration is N_frames times that.
- FRAME_DONE pulses in the cycle after the final stop-bit cycle.
- CMD_READY returns to 1 in the cycle after the last GAP cycle, or after the last STOP cycle when GAP_BITS=0. Back-to-back acceptance on that edge is legal and gives no extra idle time.
- Reset asserted at any point, including mid-bit or mid-command, has these effects:
  - TX_OUT=1, state IDLE, all counters cleared, latched command discarded.
  - No partial frame is completed.

## Configuration
- UART_CMD_TX_PERR_INJ_EN defined:
  - Adds input INJ_PERR (1 bit), latched at acceptance.
  - When it is latched 1 and PAR_EN=1, the parity bit of every frame in that command is inverted.
- Not defined: there is no such port, and parity is always correct.

## Test plan
- RF_WR, ARG0=0x0A, ARG1=0x0F, PAR_EN=1, even parity, default parameters:
  - TX_OUT carries 0xAA, 0x0A, 0x0F LSB first, each with parity bit 0.
  - Each frame is 96 cycles, and CMD_READY returns 288 cycles after acceptance.
- ALU_W_OP, A=0x08, B=0x04, fun=0x02, even parity:
  - Frames are 0xCC/p0, 0x08/p1, 0x04/p1, 0x02/p1.
  - FRAME_DONE pulses exactly 4 times.
- RF_RD, ARG0=0x0A, PAR_EN=0: two 10-bit frames (0xBB, 0x0A), 88 cycles each.
- ALU_W_NOP, fun=0x03, PAR_TYP=1 (odd): frames are 0xDD/p1 and 0x03/p1.
- RST pulsed in the middle of the 2nd frame's DATA state:
  - TX_OUT goes to 1 at once, and BUSY goes to 0.
  - A new RF_RD accepted afterwards transmits cleanly from its start bit.
- With UART_CMD_TX_PERR_INJ_EN and INJ_PERR=1, RF_WR 0x0A/0x0F even: all three parity bits are 1, and SYS_TOP flags Parity_error.
